hex_digit_scanner: RTL and testbench

// Time-multiplexes a packed multi-digit hex value onto one shared 7-segment decoder.

---
 rtl/hex_digit_scanner.sv | 122 ++++++++++++
 tb/tb_hex_digit_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: scans a packed multi-digit hex value onto one shared
// 7-segment decoder. Values are loaded into a pending buffer and moved to the
// display buffer only at a frame wrap, so a frame never mixes two values.
module hex_digit_scanner #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DEAD_CYC    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  blank_lz,
   output logic [3:0]            hex_digit,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  blank,
   output logic                  frame_done
);

   localparam int unsigned VW = 4 * DIGITS;
   localparam int unsigned PW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = $clog2(DIGITS);

   logic [PW-1:0]     prescaler_q, prescaler_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [VW-1:0]     disp_q, disp_d;
   logic [VW-1:0]     pend_q, pend_d;
   logic              pend_valid_q, pend_valid_d;
   logic [3:0]        hex_digit_q, hex_digit_d;
   logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic              blank_q, blank_d;
   logic              frame_done_q, frame_done_d;

   logic              tick_c;
   logic              last_c;
   logic [3:0]        nib_c;
   logic              upper_zero_c;

   assign tick_c = (prescaler_q == PW'(REFRESH_DIV - 1));
   assign last_c = (idx_q == IW'(DIGITS - 1));

   // Current digit's nibble, and whether it and every more significant digit are zero
   always_comb begin
      nib_c        = 4'h0;
      upper_zero_c = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            nib_c = disp_q[4*i +: 4];
         end
         if ((IW'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'h0)) begin
            upper_zero_c = 1'b0;
         end
      end
   end

   // Next-state: prescaler, scan index, double buffer and registered outputs
   always_comb begin
      prescaler_d  = prescaler_q;
      idx_d        = idx_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      hex_digit_d  = hex_digit_q;
      digit_sel_d  = digit_sel_q;
      blank_d      = blank_q;
      frame_done_d = 1'b0;

      prescaler_d = tick_c ? '0 : prescaler_q + PW'(1);

      if (tick_c) begin
         idx_d = last_c ? '0 : idx_q + IW'(1);
      end

      // Transfer at the wrap; a simultaneous load refills pend afterwards
      if (tick_c && last_c && pend_valid_q) begin
         disp_d       = pend_q;
         pend_valid_d = 1'b0;
      end

      if (load_en) begin
         pend_d       = value;
         pend_valid_d = 1'b1;
      end

      frame_done_d = tick_c && last_c;

      hex_digit_d = nib_c;
      digit_sel_d = (32'(prescaler_q) < DEAD_CYC) ? '1 : ~(DIGITS'(1) << idx_q);
      blank_d     = blank_lz && (idx_q != '0) && upper_zero_c;
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler_q  <= '0;
         idx_q        <= '0;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         hex_digit_q  <= 4'h0;
         digit_sel_q  <= '1;
         blank_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         prescaler_q  <= prescaler_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         hex_digit_q  <= hex_digit_d;
         digit_sel_q  <= digit_sel_d;
         blank_q      <= blank_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign hex_digit  = hex_digit_q;
   assign digit_sel  = digit_sel_q;
   assign blank      = blank_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Testbench for hex_digit_scanner (DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1).
// Stimulus queues expected per-slot displays; a monitor checks each slot start.
module tb_hex_digit_scanner;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [15:0] value;
   logic        blank_lz;
   logic [3:0]  hex_digit;
   logic [3:0]  digit_sel;
   logic        blank;
   logic        frame_done;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] hex;
      logic       blk;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   hex_digit_scanner #(
      .DIGITS(4),
      .REFRESH_DIV(4),
      .DEAD_CYC(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .load_en(load_en),
      .value(value),
      .blank_lz(blank_lz),
      .hex_digit(hex_digit),
      .digit_sel(digit_sel),
      .blank(blank),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] sel, input logic [3:0] hex, input logic blk);
      exp_t e;
      e.sel = sel;
      e.hex = hex;
      e.blk = blk;
      sb.push_back(e);
   endtask

   // Expected four slots of one frame for displayed value v
   task automatic push_frame(input logic [15:0] v, input logic bl);
      logic [15:0] up;
      logic [3:0]  one;
      one = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         up = v >> (4 * i);
         push_exp(~(one << i), up[3:0], bl && (i != 0) && (up == 16'h0));
      end
   endtask

   task automatic load(input logic [15:0] v);
      value   = v;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Returns on the negedge where frame_done is seen high
   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 100);
      if (!frame_done) begin
         check("frame_done_timeout", 32'(n), 32'd16);
      end
   endtask

   // Monitor: slot starts, dead-cycle length and frame_done cadence
   logic [3:0] prev_sel;
   int         f_run;
   int         fd_cnt;
   logic       fd_have;
   logic       fd_prev;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_sel = 4'hF;
         f_run    = 0;
         fd_cnt   = 0;
         fd_have  = 1'b0;
         fd_prev  = 1'b0;
      end else begin
         if (digit_sel == 4'hF) begin
            f_run++;
         end else begin
            if (prev_sel == 4'hF && sb.size() > 0) begin
               e = sb.pop_front();
               check("slot_sel", 32'(digit_sel), 32'(e.sel));
               check("slot_hex", 32'(hex_digit), 32'(e.hex));
               check("slot_blank", 32'(blank), 32'(e.blk));
               check("dead_cycles", 32'(f_run), 32'd1);
            end
            f_run = 0;
         end
         prev_sel = digit_sel;

         fd_cnt++;
         if (frame_done) begin
            if (fd_prev) check("frame_done_width", 32'd2, 32'd1);
            if (fd_have) check("frame_done_period", 32'(fd_cnt), 32'd16);
            fd_have = 1'b1;
            fd_cnt  = 0;
         end
         fd_prev = frame_done;
      end
   end

   initial begin
      reset    = 1'b1;
      load_en  = 1'b0;
      value    = 16'h0;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sel", 32'(digit_sel), 32'hF);
      check("rst_hex", 32'(hex_digit), 32'h0);
      #1 reset = 1'b0;
      @(negedge clk);

      // Basic scan of 1A3F over two frames
      load(16'h1A3F);
      wait_frame();
      push_exp(4'b1110, 4'hF, 1'b0);
      push_exp(4'b1101, 4'h3, 1'b0);
      push_exp(4'b1011, 4'hA, 1'b0);
      push_exp(4'b0111, 4'h1, 1'b0);
      wait_frame();
      push_frame(16'h1A3F, 1'b0);
      wait_frame();

      // Load mid-frame: current frame unaffected, next frame shows new value
      push_frame(16'h1A3F, 1'b0);
      repeat (6) @(negedge clk);
      load(16'h1234);
      wait_frame();
      push_exp(4'b1110, 4'h4, 1'b0);
      push_exp(4'b1101, 4'h3, 1'b0);
      push_exp(4'b1011, 4'h2, 1'b0);
      push_exp(4'b0111, 4'h1, 1'b0);
      wait_frame();
      push_frame(16'h1234, 1'b0);
      wait_frame();

      // Reset mid-scan with a pending load: outputs clear at once, pend discarded
      load(16'h5555);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_sel", 32'(digit_sel), 32'hF);
      check("midrst_hex", 32'(hex_digit), 32'h0);
      check("midrst_blank", 32'(blank), 32'h0);
      check("midrst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      check("midrst_hold_sel", 32'(digit_sel), 32'hF);
      push_exp(4'b1110, 4'h0, 1'b0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_dead", 32'(digit_sel), 32'hF);
      wait_frame();
      push_frame(16'h0000, 1'b0);
      wait_frame();

      // Leading-zero blanking
      blank_lz = 1'b1;
      load(16'h0040);
      wait_frame();
      push_exp(4'b1110, 4'h0, 1'b0);
      push_exp(4'b1101, 4'h4, 1'b0);
      push_exp(4'b1011, 4'h0, 1'b1);
      push_exp(4'b0111, 4'h0, 1'b1);
      load(16'h0000);
      wait_frame();
      push_exp(4'b1110, 4'h0, 1'b0);
      push_exp(4'b1101, 4'h0, 1'b1);
      push_exp(4'b1011, 4'h0, 1'b1);
      push_exp(4'b0111, 4'h0, 1'b1);
      wait_frame();
      blank_lz = 1'b0;
      push_frame(16'h0000, 1'b0);
      wait_frame();

      // Load on the exact wrap cycle while 1111 is pending
      load(16'h1111);
      repeat (14) @(negedge clk);
      value   = 16'hBEEF;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      check("wrap_align_fd", 32'(frame_done), 32'h1);
      push_exp(4'b1110, 4'h1, 1'b0);
      push_exp(4'b1101, 4'h1, 1'b0);
      push_exp(4'b1011, 4'h1, 1'b0);
      push_exp(4'b0111, 4'h1, 1'b0);
      wait_frame();
      push_exp(4'b1110, 4'hF, 1'b0);
      push_exp(4'b1101, 4'hE, 1'b0);
      push_exp(4'b1011, 4'hE, 1'b0);
      push_exp(4'b0111, 4'hB, 1'b0);
      wait_frame();

      // Two loads in one frame: last one wins
      load(16'h0001);
      repeat (3) @(negedge clk);
      load(16'h0002);
      wait_frame();
      push_frame(16'h0002, 1'b0);
      wait_frame();
      push_frame(16'h0002, 1'b0);
      wait_frame();

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
